// File: rtl/conv1_collect.sv
// conv1_collect: collects one OUT_W x OUT_H convolution feature map from a
// raster stream, then replays it downstream over a valid/ready handshake.
// Collection and read-back alternate; one frame is held at a time.
module conv1_collect #(
    parameter int unsigned OUT_W     = 24,
    parameter int unsigned OUT_H     = 24,
    parameter int unsigned DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 row_last,
    output logic                 frame_last,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned DEPTH  = OUT_W * OUT_H;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    // Feature-map storage; contents survive reset on purpose.
    logic [DATA_BITS-1:0] r_mem [DEPTH];

    state_t r_state;
    state_t w_state_nxt;

    // Write side counters; r_wr_base tracks wr_row*OUT_W incrementally.
    logic [COL_W-1:0]  r_wr_col;
    logic [ROW_W-1:0]  r_wr_row;
    logic [ADDR_W-1:0] r_wr_base;

    // Read side counters; they point at the next element to fetch.
    logic [COL_W-1:0]  r_rd_col;
    logic [ROW_W-1:0]  r_rd_row;
    logic [ADDR_W-1:0] r_rd_base;
    logic              r_rd_done;

    // Registered outputs.
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid_out;
    logic                 r_row_last;
    logic                 r_frame_last;
    logic                 r_frame_done;
    logic                 r_busy;
    logic                 r_overflow;

    // Next values of the registered outputs.
    logic w_valid_out_nxt;
    logic w_row_last_nxt;
    logic w_frame_last_nxt;
    logic w_frame_done_nxt;
    logic w_busy_nxt;
    logic w_overflow_nxt;

    logic              w_wr_en;
    logic              w_wr_col_end;
    logic              w_wr_row_end;
    logic              w_wr_last;
    logic [ADDR_W-1:0] w_wr_addr;

    logic              w_rd_col_end;
    logic              w_rd_row_end;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_load;
    logic              w_xfer;
    logic              w_xfer_last;

    // Address formation and handshake decode.
    always_comb begin
        w_wr_en      = (r_state == S_COLLECT) && valid_in;
        w_wr_col_end = (r_wr_col == COL_W'(OUT_W - 1));
        w_wr_row_end = (r_wr_row == ROW_W'(OUT_H - 1));
        w_wr_last    = w_wr_en && w_wr_col_end && w_wr_row_end;
        w_wr_addr    = r_wr_base + ADDR_W'(r_wr_col);

        w_rd_col_end = (r_rd_col == COL_W'(OUT_W - 1));
        w_rd_row_end = (r_rd_row == ROW_W'(OUT_H - 1));
        w_rd_last    = w_rd_col_end && w_rd_row_end;
        w_rd_addr    = r_rd_base + ADDR_W'(r_rd_col);

        w_xfer       = r_valid_out && ready_in;
        w_xfer_last  = w_xfer && r_frame_last;
        // Fetch skips the frame_done cycle so the first beat lands two
        // cycles after frame_done; afterwards it refills whenever the output
        // register is empty or being consumed.
        w_load       = (r_state == S_DRAIN) && !r_frame_done && !r_rd_done &&
                       (!r_valid_out || ready_in);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_wr_last)   w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_xfer_last) w_state_nxt = S_COLLECT;
            default:                    w_state_nxt = S_COLLECT;
        endcase
    end

    // Output logic: next values for the registered status and stream flags.
    always_comb begin
        w_valid_out_nxt  = r_valid_out;
        w_row_last_nxt   = r_row_last;
        w_frame_last_nxt = r_frame_last;
        w_frame_done_nxt = w_wr_last;
        w_busy_nxt       = (w_state_nxt == S_DRAIN);
        w_overflow_nxt   = r_overflow || ((r_state == S_DRAIN) && valid_in);
        if (w_load) begin
            w_valid_out_nxt  = 1'b1;
            w_row_last_nxt   = w_rd_col_end;
            w_frame_last_nxt = w_rd_last;
        end else if (w_xfer_last) begin
            w_valid_out_nxt  = 1'b0;
            w_row_last_nxt   = 1'b0;
            w_frame_last_nxt = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_out  <= 1'b0;
            r_row_last   <= 1'b0;
            r_frame_last <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_valid_out  <= w_valid_out_nxt;
            r_row_last   <= w_row_last_nxt;
            r_frame_last <= w_frame_last_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= w_busy_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    // Write counters: raster walk, wrapping to (0,0) after the last element.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_col  <= '0;
            r_wr_row  <= '0;
            r_wr_base <= '0;
        end else if (w_wr_en) begin
            if (w_wr_col_end) begin
                r_wr_col <= '0;
                if (w_wr_row_end) begin
                    r_wr_row  <= '0;
                    r_wr_base <= '0;
                end else begin
                    r_wr_row  <= r_wr_row + ROW_W'(1);
                    r_wr_base <= r_wr_base + ADDR_W'(OUT_W);
                end
            end else begin
                r_wr_col <= r_wr_col + COL_W'(1);
            end
        end
    end

    // Read counters: advance per fetch; r_rd_done blocks fetches past the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_col  <= '0;
            r_rd_row  <= '0;
            r_rd_base <= '0;
            r_rd_done <= 1'b0;
        end else begin
            if (w_load) begin
                if (w_rd_col_end) begin
                    r_rd_col <= '0;
                    if (w_rd_row_end) begin
                        r_rd_row  <= '0;
                        r_rd_base <= '0;
                        r_rd_done <= 1'b1;
                    end else begin
                        r_rd_row  <= r_rd_row + ROW_W'(1);
                        r_rd_base <= r_rd_base + ADDR_W'(OUT_W);
                    end
                end else begin
                    r_rd_col <= r_rd_col + COL_W'(1);
                end
            end else if (w_xfer_last) begin
                r_rd_done <= 1'b0;
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    // Registered memory read doubles as the output data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_load) begin
            r_data_out <= r_mem[w_rd_addr];
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign row_last   = r_row_last;
    assign frame_last = r_frame_last;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
